// File: rtl/mult_chk_pkg.sv
// Shared types and defaults for the multiplier result checker.
package mult_chk_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

   localparam int unsigned DefWidth  = 8;
   localparam int unsigned DefCntW   = 16;
   localparam int unsigned DefNCases = 20;

   function automatic int unsigned prod_width(input int unsigned width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/mult_golden_stage.sv
// Registered reference multiplier: captures operands and the DUT product alongside the
// full-width golden product, qualified by a valid bit.
module mult_golden_stage
   import mult_chk_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   localparam int unsigned PW = prod_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [PW-1:0]    p,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_a,
   output logic [WIDTH-1:0] q_b,
   output logic [PW-1:0]    q_p,
   output logic [PW-1:0]    q_prod
);

   logic [PW-1:0] prod;

   // Widen before multiplying so the product is never truncated.
   assign prod = PW'(a) * PW'(b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_a     <= '0;
         q_b     <= '0;
         q_p     <= '0;
         q_prod  <= '0;
      end else if (flush) begin
         q_valid <= 1'b0;
         q_a     <= '0;
         q_b     <= '0;
         q_p     <= '0;
         q_prod  <= '0;
      end else begin
         q_valid <= en;
         if (en) begin
            q_a    <= a;
            q_b    <= b;
            q_p    <= p;
            q_prod <= prod;
         end
      end
   end

endmodule

// File: rtl/mult_result_checker.sv
// Scores a candidate multiplier: compares each returned product against a golden product
// over N_CASES samples and records statistics plus the first mismatch.
module mult_result_checker
   import mult_chk_pkg::*;
#(
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned N_CASES = DefNCases,
   parameter int unsigned CNT_W   = DefCntW,
   localparam int unsigned PW = prod_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [PW-1:0]    in_p,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] case_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_a,
   output logic [WIDTH-1:0] first_err_b,
   output logic [PW-1:0]    first_err_p,
   output logic [PW-1:0]    first_err_exp,
   output logic             err_flag
);

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_CASES - 1);

   state_e           state;
   logic [CNT_W-1:0] acc_cnt;
   logic             accept;
   logic             mismatch;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [PW-1:0]    s1_p;
   logic [PW-1:0]    s1_prod;

   assign accept   = (state == StRun) && in_valid && !start;
   assign mismatch = s1_valid && (s1_p != s1_prod);

   mult_golden_stage #(
      .WIDTH (WIDTH)
   ) u_golden (
      .clk     (clk),
      .rst     (rst),
      .flush   (start),
      .en      (accept),
      .a       (in_a),
      .b       (in_b),
      .p       (in_p),
      .q_valid (s1_valid),
      .q_a     (s1_a),
      .q_b     (s1_b),
      .q_p     (s1_p),
      .q_prod  (s1_prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= StIdle;
         acc_cnt       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         case_cnt      <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         first_err_a   <= '0;
         first_err_b   <= '0;
         first_err_p   <= '0;
         first_err_exp <= '0;
         err_flag      <= 1'b0;
      end else if (start) begin
         // Start from any state aborts whatever is in flight and re-arms a clean run.
         state         <= StRun;
         acc_cnt       <= '0;
         busy          <= 1'b1;
         done          <= 1'b0;
         pass          <= 1'b0;
         case_cnt      <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         first_err_a   <= '0;
         first_err_b   <= '0;
         first_err_p   <= '0;
         first_err_exp <= '0;
         err_flag      <= 1'b0;
      end else begin
         if (s1_valid) begin
            case_cnt <= case_cnt + 1'b1;
            if (mismatch) begin
               if (err_cnt != {CNT_W{1'b1}}) begin
                  err_cnt <= err_cnt + 1'b1;
               end
               if (!err_flag) begin
                  err_flag      <= 1'b1;
                  first_err_idx <= case_cnt;
                  first_err_a   <= s1_a;
                  first_err_b   <= s1_b;
                  first_err_p   <= s1_p;
                  first_err_exp <= s1_prod;
               end
            end
         end

         unique case (state)
            StRun: begin
               if (accept) begin
                  acc_cnt <= acc_cnt + 1'b1;
                  if (acc_cnt == LastIdx) begin
                     state <= StDrain;
                  end
               end
            end
            StDrain: begin
               // The last sample commits on this edge, so fold its result into pass here.
               state <= StDone;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (err_cnt == '0) && !mismatch;
            end
            StIdle, StDone: ;
            default: state <= StIdle;
         endcase
      end
   end

endmodule
